// File: rtl/stream_remove_sched.sv
// Per-packet round-robin front end that shares one stream_remove datapath between
// NUM_REQ sources: grant a remove command, hand it to the datapath, then forward beats until last.
module stream_remove_sched #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int ID_WD        = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              rm_valid,
  input  logic [NUM_REQ*BYTE_CNT_WD-1:0]  rm_cnt,
  output logic [NUM_REQ-1:0]              rm_ready,
  input  logic [NUM_REQ-1:0]              in_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]      in_data,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0] in_keep,
  input  logic [NUM_REQ-1:0]              in_last,
  output logic [NUM_REQ-1:0]              in_ready,
  output logic                            valid_in,
  output logic [DATA_WD-1:0]              data_in,
  output logic [DATA_BYTE_WD-1:0]         keep_in,
  output logic                            last_in,
  input  logic                            ready_in,
  output logic                            valid_remove,
  output logic [BYTE_CNT_WD-1:0]          byte_remove_cnt,
  input  logic                            ready_remove,
  output logic [ID_WD-1:0]                grant_id,
  output logic                            busy,
  output logic [15:0]                     pkt_cnt
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  localparam logic [ID_WD-1:0] LAST_ID = ID_WD'(NUM_REQ - 1);

  state_t                  state;
  logic [ID_WD-1:0]        ptr;
  logic [ID_WD-1:0]        winner;
  logic [ID_WD-1:0]        next_ptr;
  logic                    found;
  logic [DATA_WD-1:0]      data_arr [NUM_REQ];
  logic [DATA_BYTE_WD-1:0] keep_arr [NUM_REQ];
  logic [BYTE_CNT_WD-1:0]  cnt_arr  [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = in_data[i*DATA_WD +: DATA_WD];
      keep_arr[i] = in_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
      cnt_arr[i]  = rm_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
    end
  end

  // Scan from the farthest offset down so the requester closest to ptr is written last and wins.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (rm_valid[idx]) begin
        found  = 1'b1;
        winner = ID_WD'(idx);
      end
    end
    next_ptr = (winner == LAST_ID) ? '0 : winner + 1'b1;
  end

  always_comb begin
    rm_ready = '0;
    in_ready = '0;
    valid_in = 1'b0;
    data_in  = '0;
    keep_in  = '0;
    last_in  = 1'b0;
    if (state == IDLE && found) rm_ready[winner] = 1'b1;
    if (state == DATA) begin
      valid_in           = in_valid[grant_id];
      data_in            = data_arr[grant_id];
      keep_in            = keep_arr[grant_id];
      last_in            = in_last[grant_id];
      in_ready[grant_id] = ready_in;
    end
  end

  assign valid_remove = (state == CMD);
  assign busy         = (state != IDLE);

  // Ownership is released only by an accepted last beat; a stalled owner keeps the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      grant_id        <= '0;
      byte_remove_cnt <= '0;
      pkt_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id        <= winner;
            ptr             <= next_ptr;
            byte_remove_cnt <= cnt_arr[winner];
            state           <= CMD;
          end
        end
        CMD: begin
          if (ready_remove) state <= DATA;
        end
        DATA: begin
          if (valid_in && ready_in && last_in) begin
            pkt_cnt <= pkt_cnt + 16'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_remove_sched.sv
// Bench for stream_remove_sched: a table of grant scenarios plus a mid-packet reset sequence,
// with forwarded beats checked against a scoreboard of what the granted source should send.
module tb_stream_remove_sched;

  localparam int NUM_REQ      = 4;
  localparam int DATA_WD      = 32;
  localparam int DATA_BYTE_WD = 4;
  localparam int BYTE_CNT_WD  = 2;
  localparam int ID_WD        = 2;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [NUM_REQ-1:0]              rm_valid;
  logic [NUM_REQ*BYTE_CNT_WD-1:0]  rm_cnt;
  logic [NUM_REQ-1:0]              rm_ready;
  logic [NUM_REQ-1:0]              in_valid;
  logic [NUM_REQ*DATA_WD-1:0]      in_data;
  logic [NUM_REQ*DATA_BYTE_WD-1:0] in_keep;
  logic [NUM_REQ-1:0]              in_last;
  logic [NUM_REQ-1:0]              in_ready;
  logic                            valid_in;
  logic [DATA_WD-1:0]              data_in;
  logic [DATA_BYTE_WD-1:0]         keep_in;
  logic                            last_in;
  logic                            ready_in;
  logic                            valid_remove;
  logic [BYTE_CNT_WD-1:0]          byte_remove_cnt;
  logic                            ready_remove;
  logic [ID_WD-1:0]                grant_id;
  logic                            busy;
  logic [15:0]                     pkt_cnt;

  stream_remove_sched #(
    .NUM_REQ(NUM_REQ), .DATA_WD(DATA_WD), .DATA_BYTE_WD(DATA_BYTE_WD),
    .BYTE_CNT_WD(BYTE_CNT_WD), .ID_WD(ID_WD)
  ) dut (
    .clk(clk), .rst(rst),
    .rm_valid(rm_valid), .rm_cnt(rm_cnt), .rm_ready(rm_ready),
    .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_ready(in_ready),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_remove(valid_remove), .byte_remove_cnt(byte_remove_cnt), .ready_remove(ready_remove),
    .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] cnts;
    int         len;
    int         exp_w;
    int         delay;
    bit         toggle;
    int         gap_start;
    int         gap_len;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t              sb[$];
  beat_t              mon_exp;
  vec_t               vecs[11];
  vec_t               rv;
  int                 errors = 0;
  int                 checks = 0;
  int                 exp_pkt = 0;
  int                 src_beat[NUM_REQ];
  int                 src_seq[NUM_REQ];
  int                 lens[NUM_REQ];
  logic [NUM_REQ-1:0] src_on = '0;
  logic [NUM_REQ-1:0] gap = '0;
  logic [NUM_REQ-1:0] hs = '0;

  function automatic logic [31:0] beat_data(input int lane, input int seq, input int b);
    return {8'(lane), 8'(seq), 8'(b), 8'h5A};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each source presents a packet of lens[i] beats; its position only advances on a handshake.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      in_data[i*DATA_WD +: DATA_WD] = beat_data(i, src_seq[i], src_beat[i]);
      in_last[i]                    = (src_beat[i] == lens[i] - 1);
      in_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD] = in_last[i] ? 4'b0111 : 4'b1111;
      in_valid[i]                   = src_on[i] & ~gap[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        src_beat[i] <= 0;
      end else if (hs[i]) begin
        if (src_beat[i] == lens[i] - 1) begin
          src_beat[i] <= 0;
          src_seq[i]  <= src_seq[i] + 1;
        end else begin
          src_beat[i] <= src_beat[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    hs = in_valid & in_ready;
    if (valid_in && ready_in) begin
      checkOutput("beat_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        checkOutput("beat", 64'({data_in, keep_in, last_in}), 64'(mon_exp));
        if (mon_exp.last) exp_pkt++;
      end
    end
  end

  // One packet: grant cycle, CMD phase (optionally stalled), then DATA until drained or aborted by reset.
  task automatic applyStimulus(input vec_t v, input int abort_after);
    int    w;
    int    cyc;
    beat_t nb;
    w        = v.exp_w;
    rm_valid = v.mask;
    rm_cnt   = v.cnts;
    lens[w]  = v.len;
    for (int b = 0; b < v.len; b++) begin
      nb.data = beat_data(w, src_seq[w], b);
      nb.keep = (b == v.len - 1) ? 4'b0111 : 4'b1111;
      nb.last = (b == v.len - 1);
      sb.push_back(nb);
    end
    @(negedge clk);
    checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    checkOutput("rm_ready_grant", 64'(rm_ready), 64'd1 << w);
    checkOutput("busy_idle", 64'(busy), 64'd0);
    checkOutput("valid_in_idle", 64'(valid_in), 64'd0);
    checkOutput("valid_remove_idle", 64'(valid_remove), 64'd0);
    @(posedge clk); #1;
    for (int k = 0; k <= v.delay; k++) begin
      ready_remove = (k == v.delay);
      @(negedge clk);
      checkOutput("valid_remove_cmd", 64'(valid_remove), 64'd1);
      checkOutput("byte_remove_cnt", 64'(byte_remove_cnt), 64'(v.cnts[2*w +: 2]));
      checkOutput("grant_id", 64'(grant_id), 64'(w));
      checkOutput("rm_ready_cmd", 64'(rm_ready), 64'd0);
      checkOutput("valid_in_cmd", 64'(valid_in), 64'd0);
      checkOutput("data_in_cmd", 64'(data_in), 64'd0);
      checkOutput("in_ready_cmd", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    ready_remove = 1'b0;
    cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      if (abort_after >= 0 && (v.len - sb.size()) == abort_after) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_pkt = 0;
        break;
      end
      ready_in = v.toggle ? cyc[0] : 1'b1;
      gap[w]   = (cyc >= v.gap_start) && (cyc < v.gap_start + v.gap_len);
      @(negedge clk);
      checkOutput("in_ready_owner", 64'(in_ready), ready_in ? (64'd1 << w) : 64'd0);
      checkOutput("valid_in_mux", 64'(valid_in), 64'(in_valid[w]));
      checkOutput("valid_remove_data", 64'(valid_remove), 64'd0);
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("packet_drained", 64'(sb.size()), 64'd0);
    gap      = '0;
    ready_in = 1'b1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'b0010, 8'b00_00_10_00, 4, 1, 0, 1'b0, 0, 0};
    vecs[1]  = '{4'b1001, 8'b11_00_00_01, 2, 3, 0, 1'b0, 0, 0};
    vecs[2]  = '{4'b1001, 8'b11_00_00_01, 1, 0, 0, 1'b0, 0, 0};
    vecs[3]  = '{4'b0100, 8'b00_01_00_00, 3, 2, 5, 1'b0, 0, 0};
    vecs[4]  = '{4'b0011, 8'b00_00_11_10, 5, 0, 0, 1'b1, 2, 3};
    vecs[5]  = '{4'b1000, 8'b10_00_00_00, 1, 3, 0, 1'b0, 0, 0};
    vecs[6]  = '{4'b1111, 8'b11_10_01_00, 2, 0, 0, 1'b0, 0, 0};
    vecs[7]  = '{4'b1111, 8'b11_10_01_00, 3, 1, 0, 1'b1, 0, 0};
    vecs[8]  = '{4'b1111, 8'b11_10_01_00, 1, 2, 0, 1'b0, 0, 0};
    vecs[9]  = '{4'b1111, 8'b11_10_01_00, 2, 3, 0, 1'b0, 0, 0};
    vecs[10] = '{4'b1111, 8'b11_10_01_00, 2, 0, 0, 1'b0, 0, 2};
    for (int i = 0; i < NUM_REQ; i++) lens[i] = 1;

    rst          = 1'b1;
    rm_valid     = '0;
    rm_cnt       = '0;
    ready_in     = 1'b1;
    ready_remove = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_valid_in", 64'(valid_in), 64'd0);
    checkOutput("reset_valid_remove", 64'(valid_remove), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_grant_id", 64'(grant_id), 64'd0);
    checkOutput("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("reset_byte_remove_cnt", 64'(byte_remove_cnt), 64'd0);
    checkOutput("reset_rm_ready", 64'(rm_ready), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    src_on = '1;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], -1);

    // Grant req2 so the pointer moves to 3, then reset after two of its four beats.
    rv = '{4'b0100, 8'b00_11_00_00, 4, 2, 0, 1'b0, 0, 0};
    applyStimulus(rv, 2);
    rm_valid = '0;
    @(negedge clk);
    checkOutput("rst_valid_in", 64'(valid_in), 64'd0);
    checkOutput("rst_valid_remove", 64'(valid_remove), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_grant_id", 64'(grant_id), 64'd0);
    checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("rst_byte_remove_cnt", 64'(byte_remove_cnt), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rv = '{4'b1111, 8'b11_10_01_00, 2, 0, 0, 1'b0, 0, 0};
    applyStimulus(rv, -1);
    rm_valid = '0;
    @(negedge clk);
    checkOutput("final_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    checkOutput("final_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
